btb_assoc: RTL and testbench
============================

# btb_assoc

Parametrised set-associative, tagged branch target buffer for the frontend BPU; successor to the direct-mapped, untagged 512-set BTB. Takes a fetch PC lookup per cycle and returns hit/target one cycle later. Accepts one resolved-branch update per cycle with round-robin way replacement. Provides a multi-cycle flush sequencer and saturating lookup and miss PMU counters.

## Interface
- NUM_SETS, 512, number of sets; power of 2, at least 2; IDX_W = log2(NUM_SETS)
- NUM_WAYS, 2, ways per set; power of 2, 1..8; WAY_W = max(1, log2(NUM_WAYS))
- PC_WIDTH, 32, PC and target width
- TAG_WIDTH, 12, stored tag width; IDX_W + 2 + TAG_WIDTH <= PC_WIDTH
- CNT_WIDTH, 32, PMU counter width
- clock  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- lkp_valid  in  1  lookup request this cycle
- lkp_pc  in  PC_WIDTH  fetch PC to look up
- rsp_valid  out  1  lookup response valid; registered copy of lkp_valid
- rsp_hit  out  1  a valid way's tag matched
- rsp_way  out  WAY_W  matching way; 0 when no hit
- rsp_target  out  PC_WIDTH  target of the matching way; 0 when no hit
- upd_valid  in  1  update/allocate request
- upd_pc  in  PC_WIDTH  branch PC
- upd_target  in  PC_WIDTH  resolved target
- flush_req  in  1  single-cycle pulse; invalidate all entries
- busy  out  1  flush in progress
- cnt_clear  in  1  synchronously zero both PMU counters
- lookup_count  out  CNT_WIDTH  accepted lookups, saturating
- miss_count  out  CNT_WIDTH  responses with rsp_hit=0, saturating

## Operation
- Set index = pc[IDX_W+1:2]; tag = pc[IDX_W+1+TAG_WIDTH:IDX_W+2]. Bits [1:0] ignored.
- Per-entry storage: valid, tag, target. Per-set storage: a round-robin victim pointer (WAY_W bits).
- Lookup: compare the tag against all ways of the set.
  - Hit when some way has valid=1 and an equal tag.
  - If several ways match (never by construction), the lowest index wins.
- Update, state IDLE only:
  - If the tag hits a valid way, overwrite that way's target. Victim pointer unchanged.
  - Else, if an invalid way exists, write the lowest-indexed one (valid=1, tag, target). Victim pointer unchanged.
  - Else, write the way at the victim pointer, then increment the pointer modulo NUM_WAYS. It wraps from NUM_WAYS-1 to 0.
- FSM states are IDLE and FLUSH.
  - IDLE -> FLUSH on flush_req. The flush index is set to 0 and busy=1.
  - In FLUSH, each cycle clears the valid bits of every way in set flush_idx and its victim pointer, then increments flush_idx.
  - FLUSH -> IDLE after clearing set NUM_SETS-1. busy=0 from the next cycle.
  - flush_req while in FLUSH restarts flush_idx at 0.
- During FLUSH:
  - Lookups are accepted and respond with rsp_hit=0 (counted as misses).
  - upd_valid is dropped silently.
- Counters:
  - lookup_count +1 per lkp_valid.
  - miss_count +1 per rsp_valid with rsp_hit=0.
  - Both saturate at 2^CNT_WIDTH-1.
  - cnt_clear has priority over increment in the same cycle.

## Timing
- Reset values:
  - All valid bits, victim pointers, rsp_valid, rsp_hit, rsp_way, rsp_target, busy, flush_idx and both counters are 0.
  - FSM state is IDLE.
  - Tags and targets are don't-care.
- Lookup latency is 1 cycle: a request at cycle N responds at N+1. Full throughput, one lookup per cycle, no backpressure.
- Update latency is 1 cycle. An update written at edge N is visible to lookups presented in cycle N+1.
- Same cycle, same set, lookup and update: the lookup sees pre-update contents (read-before-write).
- Same cycle, flush_req and upd_valid in IDLE: the update is dropped. The FSM enters FLUSH.
- Flush takes exactly NUM_SETS cycles. busy is high from the cycle after flush_req until NUM_SETS cycles later.
- Reset asserted mid-flush returns to IDLE with everything invalid.

## Test plan
- Reset -> lookup pc 0x0000_1000 -> rsp_valid=1 at N+1, rsp_hit=0; miss_count=1 and lookup_count=1.
- Update pc 0x1000 with target 0x2000, then lookup 0x1000 the next cycle -> hit, way 0, target 0x2000.
  - Lookup 0x1000 + (NUM_SETS<<2) (same set, different tag) -> miss.
- Defaults (NUM_WAYS=2): allocate three distinct tags into set 5 (targets A, B, C).
  - Ways are filled 0 then 1, then C replaces way 0.
  - Lookup of the first tag misses; lookups of tags 2 and 3 hit with B and C.
  - A fourth tag replaces way 1.
- Update a resident tag with a new target -> same way, new target returned. Victim pointer unchanged.
- Fill several sets, pulse flush_req -> busy=1 for exactly 512 cycles.
  - Updates during flush leave no entries.
  - After busy falls, all previous PCs miss.
  - flush_req mid-flush extends busy to 512 cycles from the restart.
- Force lookup_count near saturation (CNT_WIDTH=4 build): 20 lookups -> holds at 15.
  - Assert cnt_clear together with lkp_valid -> counter reads 0.

Source files
------------

// File: rtl/btb_assoc.sv
// -----------------------------------------------------------------------------
// btb_assoc
//   Set-associative, tagged branch target buffer for the frontend branch
//   predictor. One fetch-PC lookup per cycle answers with hit/way/target on
//   the following cycle. One resolved-branch update per cycle either
//   refreshes a resident entry, fills the lowest free way, or evicts the
//   round-robin victim of the set. A flush sequencer walks every set, one per
//   cycle, clearing valid bits and victim pointers. Two saturating PMU
//   counters track accepted lookups and missed responses.
//
// Ports
//   clock        single rising-edge clock
//   reset_n      asynchronous active-low reset
//   lkp_valid    lookup request this cycle
//   lkp_pc       fetch PC to look up
//   rsp_valid    lookup response valid (registered copy of lkp_valid)
//   rsp_hit      a valid way's tag matched
//   rsp_way      matching way, 0 on miss
//   rsp_target   target of the matching way, 0 on miss
//   upd_valid    update/allocate request
//   upd_pc       branch PC to update
//   upd_target   resolved branch target
//   flush_req    single-cycle pulse, invalidate every entry
//   busy         flush in progress
//   cnt_clear    synchronously zero both PMU counters
//   lookup_count accepted lookups, saturating
//   miss_count   responses without a hit, saturating
// -----------------------------------------------------------------------------
module btb_assoc #(
  parameter int NUM_SETS  = 512,
  parameter int NUM_WAYS  = 2,
  parameter int PC_WIDTH  = 32,
  parameter int TAG_WIDTH = 12,
  parameter int CNT_WIDTH = 32,
  localparam int IDX_W    = $clog2(NUM_SETS),
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 lkp_valid,
  input  logic [PC_WIDTH-1:0]  lkp_pc,
  output logic                 rsp_valid,
  output logic                 rsp_hit,
  output logic [WAY_W-1:0]     rsp_way,
  output logic [PC_WIDTH-1:0]  rsp_target,
  input  logic                 upd_valid,
  input  logic [PC_WIDTH-1:0]  upd_pc,
  input  logic [PC_WIDTH-1:0]  upd_target,
  input  logic                 flush_req,
  output logic                 busy,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] lookup_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   flush_idx_q, flush_idx_d;

  // Storage. Valid bits and victim pointers are reset; tags and targets are
  // plain RAM contents that are only meaningful under a set valid bit.
  logic [NUM_WAYS-1:0]  valid_q  [NUM_SETS];
  logic [WAY_W-1:0]     victim_q [NUM_SETS];
  logic [TAG_WIDTH-1:0] tag_q    [NUM_SETS][NUM_WAYS];
  logic [PC_WIDTH-1:0]  target_q [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0]     lkp_idx, upd_idx;
  logic [TAG_WIDTH-1:0] lkp_tag, upd_tag;

  assign lkp_idx = lkp_pc[IDX_W+1:2];
  assign lkp_tag = lkp_pc[IDX_W+1+TAG_WIDTH:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+1+TAG_WIDTH:IDX_W+2];

  // Byte-offset and high PC bits take no part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lkp_pc, upd_pc};

  // Lookup tag match. Scanning from the top way down lets the lowest
  // matching way win should duplicates ever appear.
  logic                lkp_hit;
  logic [WAY_W-1:0]    lkp_way;
  logic [PC_WIDTH-1:0] lkp_tgt;

  always_comb begin
    lkp_hit = 1'b0;
    lkp_way = '0;
    lkp_tgt = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[lkp_idx][w] && (tag_q[lkp_idx][w] == lkp_tag)) begin
        lkp_hit = 1'b1;
        lkp_way = WAY_W'(w);
        lkp_tgt = target_q[lkp_idx][w];
      end
    end
  end

  // Update way selection: resident tag first, then the lowest free way,
  // and only when the set is full the round-robin victim.
  logic             upd_en;
  logic             upd_hit;
  logic [WAY_W-1:0] upd_hit_way;
  logic             has_free;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] write_way;
  logic             advance_victim;
  logic [WAY_W-1:0] victim_next;

  always_comb begin
    upd_hit     = 1'b0;
    upd_hit_way = '0;
    has_free    = 1'b0;
    free_way    = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag)) begin
        upd_hit     = 1'b1;
        upd_hit_way = WAY_W'(w);
      end
      if (!valid_q[upd_idx][w]) begin
        has_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  // A flush request in the same cycle wins over the update.
  assign upd_en = upd_valid && (state_q == IDLE) && !flush_req;

  always_comb begin
    write_way      = victim_q[upd_idx];
    advance_victim = 1'b0;
    if (upd_hit) begin
      write_way = upd_hit_way;
    end else if (has_free) begin
      write_way = free_way;
    end else begin
      advance_victim = upd_en;
    end
  end

  // Explicit wrap keeps the single-way build pinned at way 0.
  assign victim_next = (victim_q[upd_idx] == WAY_W'(NUM_WAYS - 1))
                       ? '0 : victim_q[upd_idx] + WAY_W'(1);

  // Valid bits and victim pointers: flush clears one set per cycle, and
  // updates are only applied while idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s]  <= '0;
        victim_q[s] <= '0;
      end
    end else if (state_q == FLUSH) begin
      valid_q[flush_idx_q]  <= '0;
      victim_q[flush_idx_q] <= '0;
    end else if (upd_en) begin
      valid_q[upd_idx][write_way] <= 1'b1;
      if (advance_victim) begin
        victim_q[upd_idx] <= victim_next;
      end
    end
  end

  // Tag and target RAM. A refresh of a resident entry leaves its tag alone.
  always_ff @(posedge clock) begin
    if (upd_en) begin
      if (!upd_hit) begin
        tag_q[upd_idx][write_way] <= upd_tag;
      end
      target_q[upd_idx][write_way] <= upd_target;
    end
  end

  // Flush sequencer state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
    end
  end

  // Flush sequencer next state. A new request while flushing restarts the
  // walk from set 0.
  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end
      end
      FLUSH: begin
        if (flush_req) begin
          flush_idx_d = '0;
        end else if (flush_idx_q == IDX_W'(NUM_SETS - 1)) begin
          state_d     = IDLE;
          flush_idx_d = '0;
        end else begin
          flush_idx_d = flush_idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        flush_idx_d = '0;
      end
    endcase
  end

  assign busy = (state_q == FLUSH);

  // Registered lookup response. While flushing every lookup reports a miss.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_way    <= '0;
      rsp_target <= '0;
    end else begin
      rsp_valid <= lkp_valid;
      if (lkp_valid && lkp_hit && (state_q == IDLE)) begin
        rsp_hit    <= 1'b1;
        rsp_way    <= lkp_way;
        rsp_target <= lkp_tgt;
      end else begin
        rsp_hit    <= 1'b0;
        rsp_way    <= '0;
        rsp_target <= '0;
      end
    end
  end

  // Saturating PMU counters; clear beats increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lookup_count <= '0;
      miss_count   <= '0;
    end else if (cnt_clear) begin
      lookup_count <= '0;
      miss_count   <= '0;
    end else begin
      if (lkp_valid && (lookup_count != '1)) begin
        lookup_count <= lookup_count + CNT_WIDTH'(1);
      end
      if (rsp_valid && !rsp_hit && (miss_count != '1)) begin
        miss_count <= miss_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// -----------------------------------------------------------------------------
// tb_btb_assoc
//   Self-checking bench for btb_assoc. The main instance uses the default
//   geometry (512 sets, 2 ways); a second small instance with 4-bit counters
//   exercises counter saturation and clear priority. Expected lookup
//   responses are queued when a lookup is driven and compared when the DUT
//   presents rsp_valid.
// -----------------------------------------------------------------------------
module tb_btb_assoc;

  localparam int NUM_SETS = 512;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        lkp_valid;
  logic [31:0] lkp_pc;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [0:0]  rsp_way;
  logic [31:0] rsp_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        flush_req;
  logic        busy;
  logic        cnt_clear;
  logic [31:0] lookup_count;
  logic [31:0] miss_count;

  logic        s_lkp_valid;
  logic [31:0] s_lkp_pc;
  logic        s_rsp_valid;
  logic        s_rsp_hit;
  logic [0:0]  s_rsp_way;
  logic [31:0] s_rsp_target;
  logic        s_busy;
  logic        s_cnt_clear;
  logic [3:0]  s_lookup_count;
  logic [3:0]  s_miss_count;

  btb_assoc dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .lkp_valid    (lkp_valid),
    .lkp_pc       (lkp_pc),
    .rsp_valid    (rsp_valid),
    .rsp_hit      (rsp_hit),
    .rsp_way      (rsp_way),
    .rsp_target   (rsp_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .flush_req    (flush_req),
    .busy         (busy),
    .cnt_clear    (cnt_clear),
    .lookup_count (lookup_count),
    .miss_count   (miss_count)
  );

  btb_assoc #(.NUM_SETS(4), .CNT_WIDTH(4)) dut_small (
    .clock        (clock),
    .reset_n      (reset_n),
    .lkp_valid    (s_lkp_valid),
    .lkp_pc       (s_lkp_pc),
    .rsp_valid    (s_rsp_valid),
    .rsp_hit      (s_rsp_hit),
    .rsp_way      (s_rsp_way),
    .rsp_target   (s_rsp_target),
    .upd_valid    (1'b0),
    .upd_pc       (32'h0),
    .upd_target   (32'h0),
    .flush_req    (1'b0),
    .busy         (s_busy),
    .cnt_clear    (s_cnt_clear),
    .lookup_count (s_lookup_count),
    .miss_count   (s_miss_count)
  );

  typedef struct packed {
    logic        hit;
    logic [0:0]  way;
    logic [31:0] target;
  } rsp_t;

  rsp_t exp_q[$];

  int vec_count    = 0;
  int miscompares  = 0;
  int busy_cycles  = 0;
  int lookups_sent = 0;
  int misses_sent  = 0;

  // Set-5 PCs carrying tags 1..5.
  localparam logic [31:0] T1 = 32'h0000_0814;
  localparam logic [31:0] T2 = 32'h0000_1014;
  localparam logic [31:0] T3 = 32'h0000_1814;
  localparam logic [31:0] T4 = 32'h0000_2014;
  localparam logic [31:0] T5 = 32'h0000_2814;

  // Single comparison point for the whole bench.
  task automatic check_output(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    lkp_valid   = 1'b0;
    upd_valid   = 1'b0;
    flush_req   = 1'b0;
    cnt_clear   = 1'b0;
    s_lkp_valid = 1'b0;
    s_cnt_clear = 1'b0;
  endtask

  // Drive lookup fields for the current cycle and queue the expected answer.
  task automatic push_lookup(input logic [31:0] pc, input logic hit,
                             input logic [0:0] way, input logic [31:0] target);
    rsp_t e;
    lkp_valid = 1'b1;
    lkp_pc    = pc;
    e.hit     = hit;
    e.way     = way;
    e.target  = target;
    exp_q.push_back(e);
    lookups_sent++;
    if (!hit) misses_sent++;
  endtask

  task automatic apply_stimulus_lookup(input logic [31:0] pc, input logic hit,
                                       input logic [0:0] way, input logic [31:0] target);
    push_lookup(pc, hit, way, target);
    tick();
    lkp_valid = 1'b0;
  endtask

  task automatic apply_stimulus_update(input logic [31:0] pc, input logic [31:0] target);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = target;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    if (busy) check_output(tag, 64'(busy), 64'd0);
  endtask

  // Response monitor: compares every response against the queue head.
  always @(negedge clock) begin
    if (busy) busy_cycles++;
    if (reset_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check_output("rsp_hit",    64'(rsp_hit),    64'(e.hit));
        check_output("rsp_way",    64'(rsp_way),    64'(e.way));
        check_output("rsp_target", 64'(rsp_target), 64'(e.target));
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clear_inputs();
    lkp_pc     = '0;
    upd_pc     = '0;
    upd_target = '0;
    s_lkp_pc   = '0;
    reset_n    = 1'b0;
    repeat (3) tick();
    check_output("reset_rsp_valid", 64'(rsp_valid),    64'd0);
    check_output("reset_busy",      64'(busy),         64'd0);
    check_output("reset_lkp_cnt",   64'(lookup_count), 64'd0);
    check_output("reset_miss_cnt",  64'(miss_count),   64'd0);
    reset_n = 1'b1;
    tick();

    // First lookup after reset misses and bumps both counters.
    apply_stimulus_lookup(32'h0000_1000, 1'b0, 1'b0, 32'h0);
    repeat (2) tick();
    check_output("first_lkp_cnt",  64'(lookup_count), 64'd1);
    check_output("first_miss_cnt", 64'(miss_count),   64'd1);

    // Allocate and hit next cycle; same set with other tag misses.
    apply_stimulus_update(32'h0000_1000, 32'h0000_2000);
    apply_stimulus_lookup(32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000);
    apply_stimulus_lookup(32'h0000_1000 + (NUM_SETS << 2), 1'b0, 1'b0, 32'h0);

    // Fill set 5: ways 0, 1, then T3 evicts way 0.
    apply_stimulus_update(T1, 32'h0000_A000);
    apply_stimulus_update(T2, 32'h0000_B000);
    apply_stimulus_update(T3, 32'h0000_C000);
    apply_stimulus_lookup(T1, 1'b0, 1'b0, 32'h0);
    apply_stimulus_lookup(T2, 1'b1, 1'b1, 32'h0000_B000);
    apply_stimulus_lookup(T3, 1'b1, 1'b0, 32'h0000_C000);
    // Fourth tag evicts way 1.
    apply_stimulus_update(T4, 32'h0000_D000);
    apply_stimulus_lookup(T2, 1'b0, 1'b0, 32'h0);
    apply_stimulus_lookup(T4, 1'b1, 1'b1, 32'h0000_D000);
    apply_stimulus_lookup(T3, 1'b1, 1'b0, 32'h0000_C000);

    // Refresh of a resident tag keeps its way and leaves the victim at way 0.
    apply_stimulus_update(T3, 32'h0000_CC00);
    apply_stimulus_lookup(T3, 1'b1, 1'b0, 32'h0000_CC00);
    apply_stimulus_update(T5, 32'h0000_E000);
    apply_stimulus_lookup(T3, 1'b0, 1'b0, 32'h0);
    apply_stimulus_lookup(T5, 1'b1, 1'b0, 32'h0000_E000);
    apply_stimulus_lookup(T4, 1'b1, 1'b1, 32'h0000_D000);

    // Same-cycle lookup and update of set 7: lookup sees old contents.
    upd_valid  = 1'b1;
    upd_pc     = 32'h0000_301C;
    upd_target = 32'h0000_7000;
    push_lookup(32'h0000_301C, 1'b0, 1'b0, 32'h0);
    tick();
    clear_inputs();
    apply_stimulus_lookup(32'h0000_301C, 1'b1, 1'b0, 32'h0000_7000);

    repeat (2) tick();
    check_output("pre_flush_lkp_cnt",  64'(lookup_count), 64'(lookups_sent));
    check_output("pre_flush_miss_cnt", 64'(miss_count),   64'(misses_sent));

    // Flush with a colliding update, then hammer updates/lookups while busy.
    busy_cycles = 0;
    flush_req   = 1'b1;
    upd_valid   = 1'b1;
    upd_pc      = 32'h0000_3000;
    upd_target  = 32'h0000_9999;
    tick();
    clear_inputs();
    check_output("flush_busy_rise", 64'(busy), 64'd1);
    begin
      int n;
      n = 0;
      while (busy && n < 2000) begin
        upd_valid  = 1'b1;
        upd_pc     = 32'h0000_5004 + 32'(n % 4) * 4;
        upd_target = 32'h0000_5500;
        if (n == 0)      push_lookup(T4, 1'b0, 1'b0, 32'h0);
        else if (n % 64 == 1) push_lookup(32'h0000_5004, 1'b0, 1'b0, 32'h0);
        tick();
        clear_inputs();
        n++;
      end
      if (busy) check_output("flush_timeout", 64'(busy), 64'd0);
    end
    check_output("flush_busy_cycles", 64'(busy_cycles), 64'(NUM_SETS));

    // Everything previously resident, and everything written during flush, misses.
    apply_stimulus_lookup(32'h0000_1000, 1'b0, 1'b0, 32'h0);
    apply_stimulus_lookup(T4, 1'b0, 1'b0, 32'h0);
    apply_stimulus_lookup(T5, 1'b0, 1'b0, 32'h0);
    apply_stimulus_lookup(32'h0000_301C, 1'b0, 1'b0, 32'h0);
    apply_stimulus_lookup(32'h0000_3000, 1'b0, 1'b0, 32'h0);
    apply_stimulus_lookup(32'h0000_5004, 1'b0, 1'b0, 32'h0);
    apply_stimulus_lookup(32'h0000_5008, 1'b0, 1'b0, 32'h0);
    repeat (2) tick();
    check_output("post_flush_lkp_cnt",  64'(lookup_count), 64'(lookups_sent));
    check_output("post_flush_miss_cnt", 64'(miss_count),   64'(misses_sent));

    // Restart flush 100 cycles in: busy lasts NUM_SETS cycles past the restart.
    busy_cycles = 0;
    flush_req   = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (99) tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    wait_not_busy("restart_timeout");
    check_output("restart_busy_cycles", 64'(busy_cycles), 64'(100 + NUM_SETS));

    // Entries written after a flush behave normally again.
    apply_stimulus_update(32'h0000_1000, 32'h0000_2222);
    apply_stimulus_lookup(32'h0000_1000, 1'b1, 1'b0, 32'h0000_2222);
    repeat (2) tick();

    // Counter saturation on the 4-bit instance.
    for (int i = 0; i < 20; i++) begin
      s_lkp_valid = 1'b1;
      s_lkp_pc    = 32'(i) << 2;
      tick();
    end
    s_lkp_valid = 1'b0;
    tick();
    check_output("sat_lkp_cnt",  64'(s_lookup_count), 64'd15);
    check_output("sat_miss_cnt", 64'(s_miss_count),   64'd15);
    s_cnt_clear = 1'b1;
    s_lkp_valid = 1'b1;
    tick();
    clear_inputs();
    check_output("clr_lkp_cnt",  64'(s_lookup_count), 64'd0);
    check_output("clr_miss_cnt", 64'(s_miss_count),   64'd0);
    tick();
    check_output("after_clr_lkp_cnt",  64'(s_lookup_count), 64'd0);
    check_output("after_clr_miss_cnt", 64'(s_miss_count),   64'd1);

    // Reset in the middle of a flush returns to idle immediately.
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (10) tick();
    check_output("midflush_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #2;
    check_output("reset_midflush_busy",    64'(busy),         64'd0);
    check_output("reset_midflush_lkp_cnt", 64'(lookup_count), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    apply_stimulus_lookup(32'h0000_1000, 1'b0, 1'b0, 32'h0);
    repeat (3) tick();

    check_output("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
